// File: rtl/hazard_unit_if.sv
// hazard_unit_if: pipeline <-> hazard unit signal bundle.
//   master : pipeline side, drives ID/EX instruction info and branch outcome,
//            receives stall/flush controls, MDBusy and StallCycles.
//   slave  : hazard_unit side (inverse directions).
// Signals:
//   ID_Instruction[31:0], EX_Instruction[31:0], IDEX_MemRead, IDEX_WriteReg[4:0],
//   BranchTaken -> hazard unit
//   PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, MDBusy, StallCycles[15:0] <- hazard unit
interface hazard_unit_if;
  logic [31:0] ID_Instruction;
  logic [31:0] EX_Instruction;
  logic        IDEX_MemRead;
  logic [4:0]  IDEX_WriteReg;
  logic        BranchTaken;
  logic        PCWrite;
  logic        IFIDWrite;
  logic        IDEXBubble;
  logic        IFIDFlush;
  logic        MDBusy;
  logic [15:0] StallCycles;

  modport master (
    output ID_Instruction, EX_Instruction, IDEX_MemRead, IDEX_WriteReg, BranchTaken,
    input  PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, MDBusy, StallCycles
  );

  modport slave (
    input  ID_Instruction, EX_Instruction, IDEX_MemRead, IDEX_WriteReg, BranchTaken,
    output PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, MDBusy, StallCycles
  );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: ID-stage hazard detection for the 5-stage MIPS pipeline.
//   Load-use stall, taken-branch flush, MULT/DIV HI/LO occupancy stall and a
//   saturating stall-cycle counter.
// Ports:
//   Clock  - system clock, rising edge
//   Reset  - asynchronous, active-high reset
//   hz     - hazard_unit_if.slave (instruction info in, pipeline controls out)
// Parameters:
//   MULDIV_LATENCY - cycles HI/LO stay unavailable after a MULT/DIV leaves EX (1..15)
// Build option:
//   HAZARD_MULDIV_STALL_EN - when defined, the MULT/DIV busy FSM, MD hazard and
//   MDBusy are built; otherwise MD hazard is 0 and MDBusy is tied 0.
module hazard_unit #(
  parameter int unsigned MULDIV_LATENCY = 4
) (
  input logic       Clock,
  input logic       Reset,
  hazard_unit_if.slave hz
);

  logic [5:0] id_op;
  logic [5:0] id_funct;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_reads_rt;
  logic       load_use;
  logic       md_hazard;
  logic       stall;
  logic [15:0] stall_cnt;

  assign id_op    = hz.ID_Instruction[31:26];
  assign id_funct = hz.ID_Instruction[5:0];
  assign id_rs    = hz.ID_Instruction[25:21];
  assign id_rt    = hz.ID_Instruction[20:16];

  assign id_reads_rt = (id_op == 6'h00) || (id_op == 6'h04) || (id_op == 6'h05) ||
                       (id_op == 6'h28) || (id_op == 6'h29) || (id_op == 6'h2B);

  assign load_use = hz.IDEX_MemRead && (hz.IDEX_WriteReg != 5'd0) &&
                    ((hz.IDEX_WriteReg == id_rs) ||
                     (id_reads_rt && (hz.IDEX_WriteReg == id_rt)));

`ifdef HAZARD_MULDIV_STALL_EN
  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] MD_BUSY = 1'b1;

  logic [0:0] md_state;
  logic [3:0] md_count;
  logic [5:0] ex_op;
  logic [5:0] ex_funct;
  logic       id_md;
  logic       id_hilo;
  logic       ex_md;

  assign ex_op    = hz.EX_Instruction[31:26];
  assign ex_funct = hz.EX_Instruction[5:0];

  assign id_md   = (id_op == 6'h00) && (id_funct[5:2] == 4'b0110);
  assign id_hilo = id_md || ((id_op == 6'h00) &&
                   ((id_funct == 6'h10) || (id_funct == 6'h12)));
  assign ex_md   = (ex_op == 6'h00) && (ex_funct[5:2] == 4'b0110);

  // The EX term covers cycle T itself, before the counter has been loaded.
  assign md_hazard = id_hilo && ((md_count != '0) || ex_md);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      md_state <= RUN;
      md_count <= '0;
    end else begin
      case (md_state)
        RUN: begin
          if (ex_md) begin
            md_state <= MD_BUSY;
            md_count <= 4'(MULDIV_LATENCY);
          end
        end
        MD_BUSY: begin
          if (ex_md) begin
            md_count <= 4'(MULDIV_LATENCY);
          end else if (md_count <= 4'd1) begin
            md_count <= '0;
            md_state <= RUN;
          end else begin
            md_count <= md_count - 4'd1;
          end
        end
        default: begin
          md_state <= RUN;
          md_count <= '0;
        end
      endcase
    end
  end

  assign hz.MDBusy = (md_count != '0);
`else
  assign md_hazard = 1'b0;
  assign hz.MDBusy = 1'b0;
`endif

  // Fields not needed by the selected build are sunk here.
  logic unused_ok;
  assign unused_ok = ^{hz.ID_Instruction, hz.EX_Instruction, 4'(MULDIV_LATENCY)};

  // Reset gating makes the outputs read as pass-through while Reset is high.
  assign stall = (load_use || md_hazard) && !hz.BranchTaken && !Reset;

  always_comb begin
    hz.PCWrite    = 1'b1;
    hz.IFIDWrite  = 1'b1;
    hz.IDEXBubble = 1'b0;
    hz.IFIDFlush  = 1'b0;
    if (!Reset) begin
      if (hz.BranchTaken) begin
        hz.IFIDFlush  = 1'b1;
        hz.IDEXBubble = 1'b1;
      end else if (stall) begin
        hz.PCWrite    = 1'b0;
        hz.IFIDWrite  = 1'b0;
        hz.IDEXBubble = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign hz.StallCycles = stall_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: table-driven vectors plus hand-written multi-cycle sequences
// for hazard_unit, with expected outputs queued at drive time and popped when
// the outputs are sampled mid-cycle.
`timescale 1ns/1ps
module tb_hazard_unit;

`ifdef HAZARD_MULDIV_STALL_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] ADD  = 32'h0109_5020; // add  $10,$8,$9
  localparam logic [31:0] ADDI = 32'h2109_0005; // addi $9,$8,5
  localparam logic [31:0] SW   = 32'hAD09_0000; // sw   $9,0($8)
  localparam logic [31:0] LW   = 32'h8D09_0000; // lw   $9,0($8)
  localparam logic [31:0] BEQ  = 32'h1109_0003; // beq  $8,$9,+3
  localparam logic [31:0] MULT = 32'h0109_0018; // mult $8,$9
  localparam logic [31:0] MFLO = 32'h0000_5012; // mflo $10

  localparam logic [3:0] PASS  = 4'b1100; // {PCWrite,IFIDWrite,IDEXBubble,IFIDFlush}
  localparam logic [3:0] STALL = 4'b0010;
  localparam logic [3:0] FLUSH = 4'b1111;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  hazard_unit_if hz ();

  hazard_unit #(.MULDIV_LATENCY(4)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .hz    (hz.slave)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    string       name;
    logic [31:0] id;
    logic        mr;
    logic [4:0]  wr;
    logic        br;
    logic [3:0]  ctl;
  } vec_t;

  typedef struct {
    string       name;
    logic [3:0]  ctl;
    logic        mdb;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_cnt = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] id, input logic [31:0] ex, input logic mr,
                       input logic [4:0] wr, input logic br);
    hz.ID_Instruction = id;
    hz.EX_Instruction = ex;
    hz.IDEX_MemRead   = mr;
    hz.IDEX_WriteReg  = wr;
    hz.BranchTaken    = br;
  endtask

  // Drive one cycle, queue its expectation, check mid-cycle, then take the edge.
  task automatic step(input string nm, input logic [31:0] id, input logic [31:0] ex,
                      input logic mr, input logic [4:0] wr, input logic br,
                      input logic [3:0] ctl, input logic mdb);
    exp_t e;
    drive(id, ex, mr, wr, br);
    e.name = nm; e.ctl = ctl; e.mdb = mdb; e.cnt = exp_cnt;
    sb.push_back(e);
    @(negedge Clock);
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sb.pop_front();
      chk({e.name, ".ctl"}, 32'({hz.PCWrite, hz.IFIDWrite, hz.IDEXBubble, hz.IFIDFlush}), 32'(e.ctl));
      chk({e.name, ".mdbusy"}, 32'(hz.MDBusy), 32'(e.mdb));
      chk({e.name, ".stallcycles"}, 32'(hz.StallCycles), 32'(e.cnt));
    end
    @(posedge Clock);
    if (ctl == STALL && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    #1;
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    #1;
    Reset = 1'b0;
    exp_cnt = '0;
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{"lu_rs",      ADD,  1'b1, 5'd8,  1'b0, STALL};
    vecs[1]  = '{"lu_cleared", ADD,  1'b0, 5'd8,  1'b0, PASS};
    vecs[2]  = '{"zero_reg",   ADD,  1'b1, 5'd0,  1'b0, PASS};
    vecs[3]  = '{"addi_no_rt", ADDI, 1'b1, 5'd9,  1'b0, PASS};
    vecs[4]  = '{"add_rt",     ADD,  1'b1, 5'd9,  1'b0, STALL};
    vecs[5]  = '{"sw_rt",      SW,   1'b1, 5'd9,  1'b0, STALL};
    vecs[6]  = '{"lw_no_rt",   LW,   1'b1, 5'd9,  1'b0, PASS};
    vecs[7]  = '{"lw_rs",      LW,   1'b1, 5'd8,  1'b0, STALL};
    vecs[8]  = '{"beq_rt",     BEQ,  1'b1, 5'd9,  1'b0, STALL};
    vecs[9]  = '{"br_prio",    ADD,  1'b1, 5'd8,  1'b1, FLUSH};
    vecs[10] = '{"br_alone",   ADD,  1'b0, 5'd0,  1'b1, FLUSH};
    vecs[11] = '{"mflo_idle",  MFLO, 1'b1, 5'd9,  1'b0, PASS};
    vecs[12] = '{"other_reg",  ADD,  1'b1, 5'd31, 1'b0, PASS};

    // Reset state with a load-use condition present: outputs forced to pass-through.
    drive(ADD, NOP, 1'b1, 5'd8, 1'b0);
    #1;
    chk("reset.ctl", 32'({hz.PCWrite, hz.IFIDWrite, hz.IDEXBubble, hz.IFIDFlush}), 32'(PASS));
    chk("reset.mdbusy", 32'(hz.MDBusy), 32'd0);
    chk("reset.stallcycles", 32'(hz.StallCycles), 32'd0);
    @(posedge Clock); #1;
    chk("reset_held.stallcycles", 32'(hz.StallCycles), 32'd0);
    Reset = 1'b0;
    exp_cnt = '0;

    for (int unsigned i = 0; i < 13; i++) begin
      step(vecs[i].name, vecs[i].id, NOP, vecs[i].mr, vecs[i].wr, vecs[i].br, vecs[i].ctl, 1'b0);
    end

    // MULT in EX at T with MFLO held in ID; latency 4.
    pulse_reset();
    step("md_T",  MFLO, MULT, 1'b0, 5'd0, 1'b0, MD_EN ? STALL : PASS, 1'b0);
    for (int unsigned k = 1; k <= 4; k++) begin
      step($sformatf("md_T+%0d", k), MFLO, NOP, 1'b0, 5'd0, 1'b0, MD_EN ? STALL : PASS, MD_EN);
    end
    step("md_release", MFLO, NOP, 1'b0, 5'd0, 1'b0, PASS, 1'b0);
    chk("md.total_stalls", 32'(hz.StallCycles), MD_EN ? 32'd5 : 32'd0);

    // Branch during MD busy still flushes and the window keeps counting down.
    pulse_reset();
    step("mdbr_T",   MFLO, MULT, 1'b0, 5'd0, 1'b0, MD_EN ? STALL : PASS, 1'b0);
    step("mdbr_br",  MFLO, NOP,  1'b0, 5'd0, 1'b1, FLUSH, MD_EN);
    step("mdbr_T+2", MFLO, NOP,  1'b0, 5'd0, 1'b0, MD_EN ? STALL : PASS, MD_EN);

    // Reset at T+2 of an MD window aborts it immediately.
    pulse_reset();
    step("rst_T",   MFLO, MULT, 1'b0, 5'd0, 1'b0, MD_EN ? STALL : PASS, 1'b0);
    step("rst_T+1", MFLO, NOP,  1'b0, 5'd0, 1'b0, MD_EN ? STALL : PASS, MD_EN);
    drive(MFLO, NOP, 1'b0, 5'd0, 1'b0);
    Reset = 1'b1;
    #1;
    chk("rst_mid.mdbusy", 32'(hz.MDBusy), 32'd0);
    chk("rst_mid.stallcycles", 32'(hz.StallCycles), 32'd0);
    chk("rst_mid.ctl", 32'({hz.PCWrite, hz.IFIDWrite, hz.IDEXBubble, hz.IFIDFlush}), 32'(PASS));
    Reset = 1'b0;
    exp_cnt = '0;
    #1;
    step("rst_after", MFLO, NOP, 1'b0, 5'd0, 1'b0, PASS, 1'b0);

    // Saturation of StallCycles under a continuous load-use stall.
    pulse_reset();
    drive(ADD, NOP, 1'b1, 5'd8, 1'b0);
    repeat (65534) @(posedge Clock);
    #1;
    chk("sat.pre", 32'(hz.StallCycles), 32'hFFFE);
    repeat (6) @(posedge Clock);
    #1;
    chk("sat.hold", 32'(hz.StallCycles), 32'hFFFF);
    chk("sat.pcwrite", 32'(hz.PCWrite), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard detection stage for the 5-stage MIPS core, sitting in ID alongside the EX-stage forwarding mux control. It handles the hazards forwarding cannot resolve:
- load-use dependencies, by stalling IF/ID and bubbling ID/EX;
- taken-branch wrong-path squashing, by flushing IF/ID and ID/EX;
- multi-cycle MULT/DIV occupancy, with an internal busy FSM and counter that stalls HI/LO consumers.

It also keeps a saturating stall-cycle counter for performance debug.

## Interface
- MULDIV_LATENCY, 4: cycles HI/LO stay unavailable after a MULT/DIV leaves EX; legal 1..15.

- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- ID_Instruction  in  32  instruction currently in ID (IF/ID register output).
- EX_Instruction  in  32  instruction currently in EX (ID/EX register output).
- IDEX_MemRead  in  1  EX instruction is a load.
- IDEX_WriteReg  in  5  destination register of the EX instruction.
- BranchTaken  in  1  branch/jump resolved taken in EX this cycle.
- PCWrite  out  1  1 = PC may update.
- IFIDWrite  out  1  1 = IF/ID register may load.
- IDEXBubble  out  1  1 = ID/EX loads a NOP (control zeroed).
- IFIDFlush  out  1  1 = IF/ID loads a NOP.
- MDBusy  out  1  MULT/DIV result pending.
- StallCycles  out  16  count of stalled cycles, saturating.

## Operation
Field decode:
- ID rs = ID_Instruction[25:21]; ID rt = [20:16]; opcode = [31:26]; funct = [5:0].
- ID reads rt only for opcode 0x00 (R-type), 0x04 (BEQ), 0x05 (BNE), 0x28 (SB), 0x29 (SH), 0x2B (SW).
- MULT/DIV: opcode 0x00 with funct 0x18, 0x19, 0x1A or 0x1B.
- HI/LO consumer: opcode 0x00 with funct 0x10 (MFHI) or 0x12 (MFLO), or any MULT/DIV.

Hazard conditions:
- **Load-use:** IDEX_MemRead && IDEX_WriteReg != 0 && (IDEX_WriteReg == rs || (reads-rt && IDEX_WriteReg == rt)).
- **MD hazard:** ID holds a HI/LO consumer && (MdCount != 0 || EX holds a MULT/DIV).
- **Stall:** (load-use || MD hazard) && !BranchTaken.

Output priority, highest first:
- BranchTaken: IFIDFlush=1, IDEXBubble=1, PCWrite=1, IFIDWrite=1. Stall is suppressed because the ID instruction is wrong-path.
- Stall: PCWrite=0, IFIDWrite=0, IDEXBubble=1, IFIDFlush=0.
- Otherwise: PCWrite=1, IFIDWrite=1, IDEXBubble=0, IFIDFlush=0.

MULT/DIV FSM (4-bit MdCount):
- States are RUN (MdCount==0) and MD_BUSY (MdCount!=0).
- RUN -> MD_BUSY: EX holds a MULT/DIV; MdCount <= MULDIV_LATENCY.
- MD_BUSY: MdCount decrements each cycle. It returns to RUN when MdCount reaches 0.
- A MULT/DIV in EX while in MD_BUSY reloads MdCount to MULDIV_LATENCY. This cannot occur in a correct pipeline, because the MD hazard blocks it; the reload is defined anyway.
- BranchTaken does not affect MdCount, since the issued operation completes regardless.
- MDBusy = (MdCount != 0). It is registered-derived and excludes the same-cycle EX term.

StallCycles:
- Increments on each rising edge where Stall is 1.
- Saturates at 0xFFFF.

## Timing
- Hazard outputs (PCWrite, IFIDWrite, IDEXBubble, IFIDFlush) are combinational from the inputs and MdCount, with zero latency. They act on the same edge.
- MdCount and StallCycles are updated on the rising edge of Clock.
- Load-use stall lasts exactly one cycle: the inserted bubble clears IDEX_MemRead on the next cycle.
- MD stall: for a MULT/DIV in EX at cycle T, an ID consumer stalls cycles T..T+MULDIV_LATENCY and is released at T+MULDIV_LATENCY+1. MDBusy is high T+1..T+MULDIV_LATENCY.
- Reset, asynchronous:
  - MdCount=0, state RUN, StallCycles=0, immediately.
  - While Reset=1, outputs are forced to PCWrite=1, IFIDWrite=1, IDEXBubble=0, IFIDFlush=0, MDBusy=0, StallCycles=0.
  - Reset asserted mid MD_BUSY aborts the busy window.

## Configuration
- HAZARD_MULDIV_STALL_EN defined: MD FSM, MdCount, MD hazard and MDBusy are present as above.
- Undefined: no MD logic is compiled, MD hazard is constant 0, and MDBusy is tied 0. Load-use, branch flush and StallCycles are unchanged. MULDIV_LATENCY is ignored.

## Test plan
- Load-use stall:
  - Stimulus: IDEX_MemRead=1, IDEX_WriteReg=8; ID_Instruction=0x01095020 (add $10,$8,$9).
  - Response: PCWrite=0, IFIDWrite=0, IDEXBubble=1. StallCycles 0->1 after the edge.
  - Follow-up: next cycle with IDEX_MemRead=0 gives all outputs in pass-through.
- Zero register and rt-not-read:
  - Stimulus: IDEX_WriteReg=0 with the same add; or IDEX_WriteReg=9 with ID=0x21090005 (addi $9,$8,5).
  - Response: no stall in both cases.
- MD stall:
  - Stimulus: MULT 0x01090018 in EX at T; ID MFLO 0x00005012 held; MULDIV_LATENCY=4.
  - Response: PCWrite=0 for T..T+4; PCWrite=1 at T+5; MDBusy=1 for T+1..T+4; StallCycles=5.
- Branch priority:
  - Stimulus: BranchTaken=1 together with a load-use condition.
  - Response: IFIDFlush=1, IDEXBubble=1, PCWrite=1, IFIDWrite=1; StallCycles unchanged.
- Reset mid-busy:
  - Stimulus: assert Reset at T+2 of an MD window.
  - Response: MDBusy=0 and StallCycles=0 without waiting for a clock edge. After release, MFLO in ID does not stall.
- Saturation: force 65540 stall cycles -> StallCycles holds 0xFFFF.
